// File: rtl/sc_envscroll_shifter.sv
// Bidirectional DEPTH x WIDTH environment scroll register with a manual shift
// strobe, a programmable auto-scroll timer, an exit row, a fill level and a shift pulse.
module sc_envscroll_shifter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int PW    = 8,
    localparam int FW   = $clog2(DEPTH + 1)
) (
    input  logic                   SC_ENVSCROLL_CLOCK_50,
    input  logic                   SC_ENVSCROLL_RESET_InLow,
    input  logic                   SC_ENVSCROLL_clear_InLow,
    input  logic                   SC_ENVSCROLL_load_InLow,
    input  logic                   SC_ENVSCROLL_auto_InLow,
    input  logic                   SC_ENVSCROLL_dir_In,
    input  logic [PW-1:0]          SC_ENVSCROLL_period_InBUS,
    input  logic [WIDTH-1:0]       SC_ENVSCROLL_data_InBUS,
    output logic [WIDTH*DEPTH-1:0] SC_ENVSCROLL_data_OutBUS,
    output logic [WIDTH-1:0]       SC_ENVSCROLL_exit_OutBUS,
    output logic                   SC_ENVSCROLL_shift_OutHigh,
    output logic [FW-1:0]          SC_ENVSCROLL_fill_OutBUS,
    output logic                   SC_ENVSCROLL_full_OutHigh
);

    localparam int WD = WIDTH * DEPTH;

    logic [WD-1:0]    r_rows;
    logic [WIDTH-1:0] r_exit;
    logic             r_shift;
    logic [FW-1:0]    r_fill;
    logic [PW-1:0]    r_cnt;

    logic w_auto_en;
    logic w_tick;
    logic w_shift_req;

    // Period is nonzero whenever the timer is enabled, so period-1 cannot underflow.
    assign w_auto_en   = !SC_ENVSCROLL_auto_InLow && (SC_ENVSCROLL_period_InBUS != '0);
    assign w_tick      = w_auto_en && (r_cnt >= (SC_ENVSCROLL_period_InBUS - PW'(1)));
    assign w_shift_req = !SC_ENVSCROLL_load_InLow || w_tick;

    always_ff @(posedge SC_ENVSCROLL_CLOCK_50 or negedge SC_ENVSCROLL_RESET_InLow) begin
        if (!SC_ENVSCROLL_RESET_InLow) begin
            r_rows  <= '0;
            r_exit  <= '0;
            r_shift <= 1'b0;
            r_fill  <= '0;
            r_cnt   <= '0;
        end else if (!SC_ENVSCROLL_clear_InLow) begin
            r_rows  <= '0;
            r_exit  <= '0;
            r_shift <= 1'b0;
            r_fill  <= '0;
            r_cnt   <= '0;
        end else begin
            if (!w_auto_en || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + PW'(1);
            end

            r_shift <= w_shift_req;

            if (w_shift_req) begin
                if (!SC_ENVSCROLL_dir_In) begin
                    r_rows <= {SC_ENVSCROLL_data_InBUS, r_rows[WD-1:WIDTH]};
                    r_exit <= r_rows[WIDTH-1:0];
                end else begin
                    r_rows <= {r_rows[WD-WIDTH-1:0], SC_ENVSCROLL_data_InBUS};
                    r_exit <= r_rows[WD-1 -: WIDTH];
                end
                if (r_fill != FW'(DEPTH)) begin
                    r_fill <= r_fill + FW'(1);
                end
            end
        end
    end

    assign SC_ENVSCROLL_data_OutBUS   = r_rows;
    assign SC_ENVSCROLL_exit_OutBUS   = r_exit;
    assign SC_ENVSCROLL_shift_OutHigh = r_shift;
    assign SC_ENVSCROLL_fill_OutBUS   = r_fill;
    assign SC_ENVSCROLL_full_OutHigh  = (r_fill == FW'(DEPTH));

endmodule

// File: tb/tb_sc_envscroll_shifter.sv
// Randomised bench for sc_envscroll_shifter: an array-based row model is compared
// against the DUT every cycle, with a few hand-computed directed expectations.
module tb_sc_envscroll_shifter;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int PW = 8;
    localparam int FW = $clog2(D + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clear_n;
    logic            load_n;
    logic            auto_n;
    logic            dir;
    logic [PW-1:0]   period;
    logic [W-1:0]    din;
    logic [W*D-1:0]  data_out;
    logic [W-1:0]    exit_out;
    logic            shift_out;
    logic [FW-1:0]   fill_out;
    logic            full_out;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int p0;
    bit started = 0;

    // Reference model state
    logic [W-1:0] m_rows [D];
    logic [W-1:0] m_exit;
    bit           m_shift;
    int           m_fill;
    int           m_cnt;

    sc_envscroll_shifter #(.WIDTH(W), .DEPTH(D), .PW(PW)) dut (
        .SC_ENVSCROLL_CLOCK_50     (clk),
        .SC_ENVSCROLL_RESET_InLow  (rst_n),
        .SC_ENVSCROLL_clear_InLow  (clear_n),
        .SC_ENVSCROLL_load_InLow   (load_n),
        .SC_ENVSCROLL_auto_InLow   (auto_n),
        .SC_ENVSCROLL_dir_In       (dir),
        .SC_ENVSCROLL_period_InBUS (period),
        .SC_ENVSCROLL_data_InBUS   (din),
        .SC_ENVSCROLL_data_OutBUS  (data_out),
        .SC_ENVSCROLL_exit_OutBUS  (exit_out),
        .SC_ENVSCROLL_shift_OutHigh(shift_out),
        .SC_ENVSCROLL_fill_OutBUS  (fill_out),
        .SC_ENVSCROLL_full_OutHigh (full_out)
    );

    always #5 clk = ~clk;

    task automatic model_zero();
        for (int i = 0; i < D; i++) m_rows[i] = '0;
        m_exit  = '0;
        m_shift = 0;
        m_fill  = 0;
        m_cnt   = 0;
    endtask

    function automatic logic [W*D-1:0] model_bus();
        logic [W*D-1:0] v;
        for (int i = 0; i < D; i++) v[i*W +: W] = m_rows[i];
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_zero();
        end else if (!clear_n) begin
            model_zero();
        end else begin
            bit en, tick, req;
            logic [W-1:0] old0, oldl;
            en   = !auto_n && (int'(period) != 0);
            tick = en && (m_cnt >= int'(period) - 1);
            req  = !load_n || tick;
            m_cnt = (!en || tick) ? 0 : m_cnt + 1;
            m_shift = req;
            if (req) begin
                old0 = m_rows[0];
                oldl = m_rows[D-1];
                if (!dir) begin
                    for (int i = 0; i < D-1; i++) m_rows[i] = m_rows[i+1];
                    m_rows[D-1] = din;
                    m_exit = old0;
                end else begin
                    for (int i = D-1; i > 0; i--) m_rows[i] = m_rows[i-1];
                    m_rows[0] = din;
                    m_exit = oldl;
                end
                m_fill = (m_fill < D) ? m_fill + 1 : D;
            end
        end
    end

    task automatic chk(input string name, input logic [W*D-1:0] act, input logic [W*D-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (shift_out === 1'b1) pulses++;
            chk("rows",  data_out, model_bus());
            chk("exit",  64'(exit_out), 64'(m_exit));
            chk("shift", 64'(shift_out), 64'(m_shift));
            chk("fill",  64'(fill_out), 64'(m_fill));
            chk("full",  64'(full_out), 64'(m_fill == D));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 0; clear_n = 1; load_n = 1; auto_n = 1; dir = 0;
        period = 8'd200; din = '0;
        #22;
        rst_n = 1;
        started = 1;
        step();

        // Reset mid-activity: auto on, fill = 5, shift pulse high
        auto_n = 0;
        load_n = 0;
        for (int i = 0; i < 5; i++) begin
            din = W'(8'h30 + i);
            step();
        end
        load_n = 1;
        chk("pre_reset_fill", 64'(fill_out), 64'd5);
        #1 rst_n = 0;
        #1;
        chk("rst_rows",  data_out, '0);
        chk("rst_exit",  64'(exit_out), 64'd0);
        chk("rst_shift", 64'(shift_out), 64'd0);
        chk("rst_fill",  64'(fill_out), 64'd0);
        chk("rst_full",  64'(full_out), 64'd0);
        auto_n = 1;
        step();
        rst_n = 1;
        step();

        // Eight manual shifts toward row0, then a ninth into a full register
        dir = 0;
        load_n = 0;
        for (int i = 1; i <= 8; i++) begin
            din = W'(i);
            step();
        end
        load_n = 1;
        chk("fill8_rows", data_out, 64'h0807060504030201);
        chk("fill8_fill", 64'(fill_out), 64'd8);
        chk("fill8_full", 64'(full_out), 64'd1);
        load_n = 0; din = 8'h09;
        step();
        load_n = 1;
        chk("ninth_exit", 64'(exit_out), 64'h01);
        chk("ninth_row7", 64'(data_out[7*W +: W]), 64'h09);
        chk("ninth_fill", 64'(fill_out), 64'd8);

        // Reverse direction
        dir = 1; load_n = 0; din = 8'hAA;
        step();
        load_n = 1;
        chk("rev_row0", 64'(data_out[0 +: W]), 64'hAA);
        chk("rev_row1", 64'(data_out[W +: W]), 64'h02);
        chk("rev_exit", 64'(exit_out), 64'h09);
        step();
        chk("exit_hold", 64'(exit_out), 64'h09);

        // Auto-scroll period 3: one pulse every third cycle
        p0 = pulses;
        auto_n = 0; period = 8'd3;
        for (int i = 0; i < 30; i++) step();
        #4;
        chk("auto_p3_pulses", 64'(pulses - p0), 64'd10);
        period = 8'd0;
        p0 = pulses;
        for (int i = 0; i < 20; i++) step();
        #4;
        chk("auto_p0_pulses", 64'(pulses - p0), 64'd0);
        period = 8'd3;
        step();
        step();
        period = 8'd1;
        p0 = pulses;
        for (int i = 0; i < 5; i++) step();
        #4;
        chk("auto_p1_pulses", 64'(pulses - p0), 64'd5);
        auto_n = 1;
        step();

        // Manual strobe on the tick cycle yields a single shift
        clear_n = 0;
        step();
        clear_n = 1;
        auto_n = 0; period = 8'd3;
        step();
        step();
        load_n = 0;
        step();
        load_n = 1; auto_n = 1;
        chk("coincident_fill", 64'(fill_out), 64'd1);

        // Clear wins over a shift request in the same cycle
        load_n = 0; din = 8'h5C;
        step();
        step();
        clear_n = 0;
        step();
        clear_n = 1; load_n = 1;
        chk("clear_rows",  data_out, '0);
        chk("clear_fill",  64'(fill_out), 64'd0);
        chk("clear_shift", 64'(shift_out), 64'd0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            clear_n = ($urandom_range(0, 40) != 0);
            load_n  = ($urandom_range(0, 2) != 0);
            dir     = 1'($urandom_range(0, 1));
            din     = W'($urandom);
            if ($urandom_range(0, 15) == 0) auto_n = ~auto_n;
            if ($urandom_range(0, 20) == 0) period = PW'($urandom_range(0, 6));
            if ($urandom_range(0, 400) == 0) begin
                #1 rst_n = 0;
                step();
                rst_n = 1;
            end
            step();
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
